// File: rtl/mipi_csi_pkg.sv
// Shared definitions for the CSI-2 receive path.
// Contents: data type codes, the packet decoder FSM state type, the packet
// header struct and helpers that decode a header word and size a payload.
package mipi_csi_pkg;

    // CSI-2 data type codes
    localparam logic [5:0] DT_FRAME_START = 6'h00;
    localparam logic [5:0] DT_FRAME_END   = 6'h01;
    localparam logic [5:0] DT_LINE_START  = 6'h02;
    localparam logic [5:0] DT_LINE_END    = 6'h03;
    localparam logic [5:0] DT_RAW8        = 6'h2A;
    localparam logic [5:0] DT_RAW10       = 6'h2B;
    localparam logic [5:0] DT_RAW12       = 6'h2C;

    // Data types below this value are short packets
    localparam logic [5:0] DT_LONG_MIN    = 6'h10;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
        logic [7:0]  ecc;
    } header_t;

    // Split a lane-aligned header word into its fields.
    function automatic header_t decode_header(input logic [31:0] word);
        header_t h;
        h.vc  = word[7:6];
        h.dt  = word[5:0];
        h.wc  = {word[23:16], word[15:8]};
        h.ecc = word[31:24];
        return h;
    endfunction

    // Index of the last 32-bit payload word, ceil(wc/4) - 1. Storing the
    // count minus one keeps wc = 0xFFFF (16384 words) inside 14 bits.
    // Caller guarantees wc != 0.
    function automatic logic [13:0] last_word_index(input logic [15:0] wc);
        logic [16:0] words;
        words = ({1'b0, wc} + 17'd3) >> 2;
        return 14'(words - 17'd1);
    endfunction

endpackage

// File: rtl/mipi_csi_packet_decoder.sv
// CSI-2 packet decoder for a 4-lane, lane-aligned byte stream.
// Parses packet headers, tracks frame start/end, and forwards the payload of
// long packets matching DATA_TYPE on VIRTUAL_CHANNEL with one cycle latency.
// Headers and CRC are stripped.
// Ports:
//   clk_i          byte clock
//   reset_i        synchronous active-high reset
//   data_i         aligned lane bytes, lane0 in [7:0]
//   data_valid_i   high for every cycle of an HS burst, header first
//   output_o       forwarded payload word, same byte order as data_i
//   output_valid_o output_o holds a payload word
//   line_valid_o   high while payload words of a line are forwarded
//   frame_valid_o  set by Frame Start, cleared by Frame End
//   line_count_o   lines forwarded since the last Frame Start
//   error_o        one-cycle pulse on a truncated packet
module mipi_csi_packet_decoder
    import mipi_csi_pkg::*;
#(
    parameter logic [5:0] DATA_TYPE       = DT_RAW10,
    parameter logic [1:0] VIRTUAL_CHANNEL = 2'd0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] data_i,
    input  logic        data_valid_i,
    output logic [31:0] output_o,
    output logic        output_valid_o,
    output logic        line_valid_o,
    output logic        frame_valid_o,
    output logic [15:0] line_count_o,
    output logic        error_o
);

    state_t      state, state_next;
    logic [13:0] words_left, words_left_next;
    logic [31:0] out_data_next;
    logic        out_valid_next;
    logic        frame_valid_next;
    logic [15:0] line_count_next;
    logic        error_next;
    header_t     hdr;

    assign hdr = decode_header(data_i);

    // ECC is decoded but deliberately not checked.
    logic unused_ecc;
    assign unused_ecc = ^hdr.ecc;

    always_comb begin
        state_next       = state;
        words_left_next  = words_left;
        out_data_next    = output_o;
        out_valid_next   = 1'b0;
        frame_valid_next = frame_valid_o;
        line_count_next  = line_count_o;
        error_next       = 1'b0;

        case (state)
            IDLE: begin
                if (data_valid_i) begin
                    state_next = DRAIN;
                    if (hdr.vc == VIRTUAL_CHANNEL) begin
                        if (hdr.dt == DT_FRAME_START) begin
                            frame_valid_next = 1'b1;
                            line_count_next  = '0;
                        end else if (hdr.dt == DT_FRAME_END) begin
                            frame_valid_next = 1'b0;
                        end else if (hdr.dt >= DT_LONG_MIN && hdr.dt == DATA_TYPE &&
                                     hdr.wc != 16'd0) begin
                            words_left_next = last_word_index(hdr.wc);
                            state_next      = PAYLOAD;
                        end
                    end
                end
            end

            PAYLOAD: begin
                if (data_valid_i) begin
                    // Trailing CRC/filler bytes in the last word pass through as-is
                    out_data_next  = data_i;
                    out_valid_next = 1'b1;
                    if (words_left == 14'd0) begin
                        line_count_next = line_count_o + 16'd1;
                        state_next      = DRAIN;
                    end else begin
                        words_left_next = words_left - 14'd1;
                    end
                end else begin
                    // At least one word was still owed: the burst was cut short
                    error_next = 1'b1;
                    state_next = IDLE;
                end
            end

            DRAIN: begin
                if (!data_valid_i) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state          <= IDLE;
            words_left     <= '0;
            output_o       <= '0;
            output_valid_o <= 1'b0;
            line_valid_o   <= 1'b0;
            frame_valid_o  <= 1'b0;
            line_count_o   <= '0;
            error_o        <= 1'b0;
        end else begin
            state          <= state_next;
            words_left     <= words_left_next;
            output_o       <= out_data_next;
            output_valid_o <= out_valid_next;
            line_valid_o   <= out_valid_next;
            frame_valid_o  <= frame_valid_next;
            line_count_o   <= line_count_next;
            error_o        <= error_next;
        end
    end

endmodule

// File: tb/tb_mipi_csi_packet_decoder.sv
// Directed testbench for mipi_csi_packet_decoder.
module tb_mipi_csi_packet_decoder;

    logic        clk_i;
    logic        reset_i;
    logic [31:0] data_i;
    logic        data_valid_i;
    logic [31:0] output_o;
    logic        output_valid_o;
    logic        line_valid_o;
    logic        frame_valid_o;
    logic [15:0] line_count_o;
    logic        error_o;

    int checks = 0;
    int errors = 0;
    int exp_lines = 0;
    logic exp_frame = 1'b0;

    mipi_csi_packet_decoder dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .data_i         (data_i),
        .data_valid_i   (data_valid_i),
        .output_o       (output_o),
        .output_valid_o (output_valid_o),
        .line_valid_o   (line_valid_o),
        .frame_valid_o  (frame_valid_o),
        .line_count_o   (line_count_o),
        .error_o        (error_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Drive one input cycle; returns 1 time unit after the capturing edge.
    task automatic step(input logic [31:0] d, input logic v);
        @(negedge clk_i);
        data_i       = d;
        data_valid_i = v;
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] payload(input int i);
        logic [31:0] base;
        base = 32'h12345678;
        return (i == 14) ? 32'hDDDDDD00 : base + 32'(i) * 32'h11111111;
    endfunction

    task automatic test_reset();
        reset_i = 1'b1;
        data_i = '0;
        data_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({output_o, output_valid_o, line_valid_o, frame_valid_o, line_count_o, error_o}
            !== 52'd0) begin
            errors++;
            $display("FAIL reset_outputs: got out=%h ov=%b lv=%b fv=%b lc=%0d err=%b want all 0",
                     output_o, output_valid_o, line_valid_o, frame_valid_o, line_count_o, error_o);
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        exp_frame = 1'b0;
        exp_lines = 0;
    endtask

    task automatic test_frame_start();
        step(32'h00000000, 1'b1);
        exp_frame = 1'b1;
        exp_lines = 0;
        checks++;
        if (frame_valid_o !== 1'b1 || line_count_o !== 16'd0 || output_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL frame_start: got fv=%b lc=%0d ov=%b want fv=1 lc=0 ov=0",
                     frame_valid_o, line_count_o, output_valid_o);
        end
        step(32'h0, 1'b0);
    endtask

    task automatic test_raw10_line();
        int vcount;
        vcount = 0;
        step(32'h12003C2B, 1'b1);
        checks++;
        if (output_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL line_header_not_forwarded: got ov=%b want 0", output_valid_o);
        end
        for (int i = 0; i < 15; i++) begin
            step(payload(i), 1'b1);
            if (output_valid_o === 1'b1) vcount++;
            checks++;
            if (output_valid_o !== 1'b1 || line_valid_o !== 1'b1 || output_o !== payload(i)) begin
                errors++;
                $display("FAIL line_word%0d: got ov=%b lv=%b out=%h want ov=1 lv=1 out=%h",
                         i, output_valid_o, line_valid_o, output_o, payload(i));
            end
        end
        step(32'hA5A5BEEF, 1'b1);
        if (output_valid_o === 1'b1) vcount++;
        exp_lines++;
        checks++;
        if (output_valid_o !== 1'b0 || line_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL line_crc_dropped: got ov=%b lv=%b want 0 0", output_valid_o, line_valid_o);
        end
        checks++;
        if (line_count_o !== 16'(exp_lines) || vcount != 15) begin
            errors++;
            $display("FAIL line_count: got lc=%0d words=%0d want lc=%0d words=15",
                     line_count_o, vcount, exp_lines);
        end
        step(32'h0, 1'b0);
    endtask

    task automatic test_filter(input logic [31:0] header);
        int vcount;
        vcount = 0;
        step(header, 1'b1);
        if (output_valid_o === 1'b1) vcount++;
        for (int i = 0; i < 16; i++) begin
            step(payload(i), 1'b1);
            if (output_valid_o === 1'b1 || line_valid_o === 1'b1) vcount++;
        end
        step(32'h0, 1'b0);
        checks++;
        if (vcount != 0 || frame_valid_o !== exp_frame || line_count_o !== 16'(exp_lines)) begin
            errors++;
            $display("FAIL filter_%h: got words=%0d fv=%b lc=%0d want words=0 fv=%b lc=%0d",
                     header, vcount, frame_valid_o, line_count_o, exp_frame, exp_lines);
        end
    endtask

    task automatic test_short_wc();
        // WC = 5: two words forwarded, third dropped
        step(32'h0000052B, 1'b1);
        step(32'hAAAA0001, 1'b1);
        checks++;
        if (output_valid_o !== 1'b1 || output_o !== 32'hAAAA0001) begin
            errors++;
            $display("FAIL wc5_word0: got ov=%b out=%h want 1 aaaa0001", output_valid_o, output_o);
        end
        step(32'hBBBB0002, 1'b1);
        checks++;
        if (output_valid_o !== 1'b1 || output_o !== 32'hBBBB0002) begin
            errors++;
            $display("FAIL wc5_word1: got ov=%b out=%h want 1 bbbb0002", output_valid_o, output_o);
        end
        step(32'hCCCC0003, 1'b1);
        exp_lines++;
        checks++;
        if (output_valid_o !== 1'b0 || line_count_o !== 16'(exp_lines)) begin
            errors++;
            $display("FAIL wc5_end: got ov=%b lc=%0d want ov=0 lc=%0d",
                     output_valid_o, line_count_o, exp_lines);
        end
        step(32'h0, 1'b0);
        // WC = 3: one word
        step(32'h0000032B, 1'b1);
        step(32'hDDDD0004, 1'b1);
        checks++;
        if (output_valid_o !== 1'b1 || output_o !== 32'hDDDD0004) begin
            errors++;
            $display("FAIL wc3_word0: got ov=%b out=%h want 1 dddd0004", output_valid_o, output_o);
        end
        step(32'hEEEE0005, 1'b1);
        exp_lines++;
        checks++;
        if (output_valid_o !== 1'b0 || line_count_o !== 16'(exp_lines)) begin
            errors++;
            $display("FAIL wc3_end: got ov=%b lc=%0d want ov=0 lc=%0d",
                     output_valid_o, line_count_o, exp_lines);
        end
        step(32'h0, 1'b0);
        // WC = 0: nothing forwarded, no line counted
        step(32'h0000002B, 1'b1);
        step(32'hFFFF0006, 1'b1);
        checks++;
        if (output_valid_o !== 1'b0 || line_count_o !== 16'(exp_lines)) begin
            errors++;
            $display("FAIL wc0: got ov=%b lc=%0d want ov=0 lc=%0d",
                     output_valid_o, line_count_o, exp_lines);
        end
        step(32'h0, 1'b0);
    endtask

    task automatic test_truncation();
        int bad;
        bad = 0;
        step(32'h12003C2B, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(payload(i), 1'b1);
            if (output_valid_o !== 1'b1 || output_o !== payload(i) || error_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL trunc_words: got %0d bad words want 0", bad);
        end
        step(32'h0, 1'b0);
        checks++;
        if (error_o !== 1'b1 || output_valid_o !== 1'b0 || line_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL trunc_error: got err=%b ov=%b lv=%b want err=1 ov=0 lv=0",
                     error_o, output_valid_o, line_valid_o);
        end
        step(32'h0, 1'b0);
        checks++;
        if (error_o !== 1'b0 || line_count_o !== 16'(exp_lines)) begin
            errors++;
            $display("FAIL trunc_after: got err=%b lc=%0d want err=0 lc=%0d",
                     error_o, line_count_o, exp_lines);
        end
        test_raw10_line();
    endtask

    task automatic test_max_wc();
        int vcount;
        vcount = 0;
        step(32'h00FFFF2B, 1'b1);
        for (int i = 0; i < 16385; i++) begin
            step(32'(i), 1'b1);
            if (output_valid_o === 1'b1) vcount++;
        end
        step(32'h0, 1'b0);
        exp_lines++;
        checks++;
        if (vcount != 16384 || line_count_o !== 16'(exp_lines)) begin
            errors++;
            $display("FAIL max_wc: got words=%0d lc=%0d want words=16384 lc=%0d",
                     vcount, line_count_o, exp_lines);
        end
    endtask

    task automatic test_frame_sequence();
        test_frame_start();
        for (int l = 0; l < 7; l++) test_raw10_line();
        step(32'h00000001, 1'b1);
        exp_frame = 1'b0;
        checks++;
        if (frame_valid_o !== 1'b0 || line_count_o !== 16'd7) begin
            errors++;
            $display("FAIL frame_end: got fv=%b lc=%0d want fv=0 lc=7", frame_valid_o, line_count_o);
        end
        step(32'h0, 1'b0);
    endtask

    task automatic test_reset_mid_line();
        test_frame_start();
        step(32'h12003C2B, 1'b1);
        for (int i = 0; i < 3; i++) step(payload(i), 1'b1);
        @(negedge clk_i);
        reset_i = 1'b1;
        data_i = payload(3);
        @(posedge clk_i);
        #1;
        checks++;
        if ({output_o, output_valid_o, line_valid_o, frame_valid_o, line_count_o, error_o}
            !== 52'd0) begin
            errors++;
            $display("FAIL reset_mid_line: got out=%h ov=%b lv=%b fv=%b lc=%0d err=%b want all 0",
                     output_o, output_valid_o, line_valid_o, frame_valid_o, line_count_o, error_o);
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        data_valid_i = 1'b0;
        exp_frame = 1'b0;
        exp_lines = 0;
        step(32'h0, 1'b0);
        checks++;
        if (error_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_error: got err=%b want 0", error_o);
        end
        test_raw10_line();
    endtask

    initial begin
        test_reset();
        test_frame_start();
        test_raw10_line();
        test_filter(32'h12003C6B);
        test_filter(32'h12003C2A);
        test_short_wc();
        test_truncation();
        test_raw10_line();  // immediately follows the previous burst: back to back
        test_max_wc();
        test_frame_sequence();
        test_reset_mid_line();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
